// File: rtl/lsu_mem_master.sv
// Load/store initiator: one CPU access at a time, sub-word loads extracted from a word-wide
// memory, byte/halfword stores done as read-modify-write. Optional macro STORE_TRACE_EN prints each committed store.
module lsu_mem_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TO  = 2'b10;

    localparam int              CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            OP_LW, OP_SW:         return (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH: return lane[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] lane,
                                                input logic [15:0] wd, input logic [31:0] word);
        logic [31:0] res;
        res = word;
        case (op)
            OP_SB: begin
                case (lane)
                    2'd0:    res[7:0]   = wd[7:0];
                    2'd1:    res[15:8]  = wd[7:0];
                    2'd2:    res[23:16] = wd[7:0];
                    default: res[31:24] = wd[7:0];
                endcase
            end
            OP_SH: begin
                if (lane[1]) begin
                    res[31:16] = wd;
                end else begin
                    res[15:0] = wd;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [1:0]          lane_q, lane_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic [1:0]          resp_err_q, resp_err_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                timeout_hit_s;

    // The limit cycle still honours a late ack; only a missing ack on it times out.
    assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    cnt_d   = {CNT_W{1'b0}};
                    if (is_misaligned(req_op, req_addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = ERR_MIS;
                    end else if (req_op == OP_SW) begin
                        state_d     = S_WR;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = S_RD;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    cnt_d = {CNT_W{1'b0}};
                    if ((op_q == OP_SH) || (op_q == OP_SB)) begin
                        state_d     = S_WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = store_merge(op_q, lane_q, wdata_q, mem_rdata);
                    end else begin
                        state_d      = S_RESP;
                        mem_req_d    = 1'b0;
                        resp_rdata_d = load_extract(op_q, lane_q, mem_rdata);
                        resp_err_d   = ERR_OK;
                    end
                end else if (timeout_hit_s) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = ERR_TO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = ERR_OK;
                end else if (timeout_hit_s) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = ERR_TO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        resp_valid_d = (state_d == S_RESP);
        req_ready_d  = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            lane_q       <= 2'd0;
            wdata_q      <= 16'd0;
            cnt_q        <= {CNT_W{1'b0}};
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef STORE_TRACE_EN
    logic [31:0] pc_q;

    // Capture the issuing PC for the store trace
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'd0;
        end else if ((state_q == S_IDLE) && req_valid && req_ready_q) begin
            pc_q <= req_pc;
        end else begin
            pc_q <= pc_q;
        end
    end

    // Print the full committed word once the write phase is acknowledged
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_WR) && mem_ack) begin
            $display("@%h: *%h <= %h", pc_q, mem_addr_q, mem_wdata_q);
        end
    end
`else
    logic unused_pc_s;
    assign unused_pc_s = ^req_pc;
`endif

endmodule
